// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM state encoding, grant IDs and counter width.
package mem_arbiter_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ArbIdle  = 2'd0,
    ArbIssue = 2'd1,
    ArbWait  = 2'd2
  } arb_state_e;

  typedef enum logic {
    GntI = 1'b0,
    GntD = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, data port and memory-side signals around the arbiter.
// slave is the arbiter's view; master is the pipeline/memory view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              stall;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata, stall
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata, stall
  );
endinterface

// File: rtl/mem_arbiter_arb_grant.sv
// Combinational grant pick: masks a port during its own ack cycle, then picks D over I,
// or the port not granted last when MEM_ARB_RR_EN is defined.
module arb_grant
  import mem_arbiter_pkg::*;
(
  input  logic i_i_req,
  input  logic i_d_req,
  input  logic i_i_ack,
  input  logic i_d_ack,
  input  gnt_e i_last,
  output logic o_valid,
  output gnt_e o_id
);
  logic w_i_elig;
  logic w_d_elig;

  assign w_i_elig = i_i_req & ~i_i_ack;
  assign w_d_elig = i_d_req & ~i_d_ack;

`ifdef MEM_ARB_RR_EN
  always_comb begin
    o_valid = w_i_elig | w_d_elig;
    o_id    = GntD;
    if (w_i_elig && w_d_elig) begin
      o_id = (i_last == GntD) ? GntI : GntD;
    end else if (w_i_elig) begin
      o_id = GntI;
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = i_last;

  always_comb begin
    o_valid = w_i_elig | w_d_elig;
    o_id    = GntD;
    if (w_i_elig && !w_d_elig) begin
      o_id = GntI;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serializes fetch and load/store accesses onto one single-port memory and acks each port.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed D-over-I priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);

  arb_state_e        r_state;
  arb_state_e        w_next_state;
  gnt_e              r_gnt;
  gnt_e              w_gnt_id;
  gnt_e              w_last;
  logic              w_gnt_valid;
  logic              w_issue;
  logic              w_done;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_i_ack;
  logic              r_d_ack;

  arb_grant u_grant (
    .i_i_req (bus.i_req),
    .i_d_req (bus.d_req),
    .i_i_ack (r_i_ack),
    .i_d_ack (r_d_ack),
    .i_last  (w_last),
    .o_valid (w_gnt_valid),
    .o_id    (w_gnt_id)
  );

`ifdef MEM_ARB_RR_EN
  gnt_e r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= GntI;
    end else if (r_state == ArbIssue) begin
      r_last <= r_gnt;
    end
  end

  assign w_last = r_last;
`else
  assign w_last = GntI;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ArbIdle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ArbIdle: begin
        if (w_gnt_valid) begin
          w_next_state = ArbIssue;
        end
      end
      ArbIssue: begin
        w_issue      = 1'b1;
        w_next_state = ArbWait;
      end
      ArbWait: begin
        if (r_cnt == CNT_W'(1)) begin
          w_done       = 1'b1;
          w_next_state = ArbIdle;
        end
      end
      default: w_next_state = ArbIdle;
    endcase
  end

  // Fetches never write, so an I grant clears the latched write enable but keeps old wdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt     <= GntI;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      if (r_state == ArbIdle && w_gnt_valid) begin
        r_gnt <= w_gnt_id;
        if (w_gnt_id == GntD) begin
          r_addr  <= bus.d_addr;
          r_we    <= bus.d_we;
          r_wdata <= bus.d_wdata;
        end else begin
          r_addr <= bus.i_addr;
          r_we   <= 1'b0;
        end
      end
      if (w_issue) begin
        r_cnt <= LAT_LOAD;
      end else if (r_state == ArbWait) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_done) begin
        if (r_gnt == GntI) begin
          r_i_rdata <= bus.m_rdata;
          r_i_ack   <= 1'b1;
        end else begin
          if (!r_we) begin
            r_d_rdata <= bus.m_rdata;
          end
          r_d_ack <= 1'b1;
        end
      end
    end
  end

  assign bus.m_en    = w_issue;
  assign bus.m_we    = w_issue & r_we;
  assign bus.m_addr  = r_addr;
  assign bus.m_wdata = r_wdata;
  assign bus.i_rdata = r_i_rdata;
  assign bus.i_ack   = r_i_ack;
  assign bus.d_rdata = r_d_rdata;
  assign bus.d_ack   = r_d_ack;
  assign bus.stall   = ~rst & ((bus.i_req & ~r_i_ack) | (bus.d_req & ~r_d_ack));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances with MEM_LAT = 2, 1 and 15, each with a
// latency-accurate memory model that only presents valid read data in the expected cycle.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic        iReq   [3];
  logic [31:0] iAddr  [3];
  logic        dReq   [3];
  logic        dWe    [3];
  logic [31:0] dAddr  [3];
  logic [31:0] dWdata [3];
  logic        iAck   [3];
  logic [31:0] iRdata [3];
  logic        dAck   [3];
  logic [31:0] dRdata [3];
  logic        mEn    [3];
  logic        mWe    [3];
  logic [31:0] mAddr  [3];
  logic [31:0] mWdata [3];
  logic        stall  [3];

  int checkCount = 0;
  int errCount   = 0;

  function automatic logic [31:0] memModel(input logic [31:0] addr);
    case (addr)
      32'h0000_0100: return 32'h2002_0005;
      32'h0000_0040: return 32'hDEAD_BEEF;
      default:       return addr ^ 32'hA5A5_0000;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gDut
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 15);

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    logic [31:0] memData = '0;
    int          memRem  = 0;

    // Read data is only valid during the single cycle MEM_LAT after the strobe cycle.
    always @(posedge clk) begin
      if (bus.m_en && !bus.m_we) begin
        memRem  <= LAT;
        memData <= memModel(bus.m_addr);
      end else if (memRem > 0) begin
        memRem <= memRem - 1;
      end
    end

    assign bus.m_rdata = (memRem == 1) ? memData : 32'hBAD0_BAD0;
    assign bus.i_req   = iReq[g];
    assign bus.i_addr  = iAddr[g];
    assign bus.d_req   = dReq[g];
    assign bus.d_we    = dWe[g];
    assign bus.d_addr  = dAddr[g];
    assign bus.d_wdata = dWdata[g];
    assign iAck[g]     = bus.i_ack;
    assign iRdata[g]   = bus.i_rdata;
    assign dAck[g]     = bus.d_ack;
    assign dRdata[g]   = bus.d_rdata;
    assign mEn[g]      = bus.m_en;
    assign mWe[g]      = bus.m_we;
    assign mAddr[g]    = bus.m_addr;
    assign mWdata[g]   = bus.m_wdata;
    assign stall[g]    = bus.stall;
  end

  task automatic applyStimulus(input int idx, input logic iReqV, input logic [31:0] iAddrV,
                               input logic dReqV, input logic dWeV, input logic [31:0] dAddrV,
                               input logic [31:0] dWdataV);
    iReq[idx]   = iReqV;
    iAddr[idx]  = iAddrV;
    dReq[idx]   = dReqV;
    dWe[idx]    = dWeV;
    dAddr[idx]  = dAddrV;
    dWdata[idx] = dWdataV;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  int lat1;
  int lat15;
  logic [31:0] rd1;
  logic [31:0] rd15;

  initial begin
    for (int k = 0; k < 3; k++) applyStimulus(k, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset values, with a fetch request held to show stall is forced low.
    $display("[TB] reset values");
    rst = 1'b1;
    iReq[0] = 1'b1;
    nextCycle();
    nextCycle();
    sample();
    checkOutput("rst i_ack",   32'(iAck[0]),  32'h0);
    checkOutput("rst d_ack",   32'(dAck[0]),  32'h0);
    checkOutput("rst m_en",    32'(mEn[0]),   32'h0);
    checkOutput("rst m_we",    32'(mWe[0]),   32'h0);
    checkOutput("rst m_addr",  mAddr[0],      32'h0);
    checkOutput("rst m_wdata", mWdata[0],     32'h0);
    checkOutput("rst i_rdata", iRdata[0],     32'h0);
    checkOutput("rst d_rdata", dRdata[0],     32'h0);
    checkOutput("rst stall",   32'(stall[0]), 32'h0);
    iReq[0] = 1'b0;
    nextCycle();
    rst = 1'b0;
    nextCycle();

    // Fetch only: m_en in cycle 1, i_ack in cycle 4, stall in cycles 0..3.
    $display("[TB] fetch only");
    applyStimulus(0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c <= 5; c++) begin
      sample();
      checkOutput($sformatf("fetch m_en c%0d", c),  32'(mEn[0]),   32'(c == 1));
      checkOutput($sformatf("fetch i_ack c%0d", c), 32'(iAck[0]),  32'(c == 4));
      checkOutput($sformatf("fetch stall c%0d", c), 32'(stall[0]), 32'(c <= 3));
      if (c == 1) checkOutput("fetch m_addr", mAddr[0], 32'h100);
      if (c == 4) checkOutput("fetch i_rdata", iRdata[0], 32'h2002_0005);
      nextCycle();
      if (c == 4) applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    end

    // Simultaneous requests: D first (ack 4), I issued in cycle 5, acked in cycle 8.
    $display("[TB] simultaneous load and fetch");
    applyStimulus(0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h40, 32'h0);
    for (int c = 0; c <= 8; c++) begin
      sample();
      checkOutput($sformatf("both m_en c%0d", c),  32'(mEn[0]),   32'(c == 1 || c == 5));
      checkOutput($sformatf("both d_ack c%0d", c), 32'(dAck[0]),  32'(c == 4));
      checkOutput($sformatf("both i_ack c%0d", c), 32'(iAck[0]),  32'(c == 8));
      checkOutput($sformatf("both stall c%0d", c), 32'(stall[0]), 32'(c < 8));
      if (c == 1) checkOutput("both m_addr D", mAddr[0], 32'h40);
      if (c == 5) checkOutput("both m_addr I", mAddr[0], 32'h200);
      if (c == 4) checkOutput("both d_rdata", dRdata[0], 32'hDEAD_BEEF);
      if (c == 8) checkOutput("both i_rdata", iRdata[0], 32'hA5A5_0200);
      nextCycle();
      if (c == 4) applyStimulus(0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h40, 32'h0);
      if (c == 8) applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    end

    // Store: one write strobe with the latched values, ack in cycle 4, d_rdata kept.
    $display("[TB] store");
    applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'h1234_5678);
    for (int c = 0; c <= 4; c++) begin
      sample();
      checkOutput($sformatf("store m_en c%0d", c),  32'(mEn[0]),  32'(c == 1));
      checkOutput($sformatf("store m_we c%0d", c),  32'(mWe[0]),  32'(c == 1));
      checkOutput($sformatf("store d_ack c%0d", c), 32'(dAck[0]), 32'(c == 4));
      if (c == 1) checkOutput("store m_addr", mAddr[0], 32'h80);
      if (c == 1) checkOutput("store m_wdata", mWdata[0], 32'h1234_5678);
      if (c == 4) checkOutput("store d_rdata kept", dRdata[0], 32'hDEAD_BEEF);
      nextCycle();
      if (c == 4) applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    end

    // Reset in the WAIT cycle of a fetch: no ack, then reissue from the cycle after release.
    $display("[TB] reset mid-access");
    applyStimulus(0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c <= 7; c++) begin
      if (c == 2) rst = 1'b1;
      if (c == 3) rst = 1'b0;
      sample();
      checkOutput($sformatf("rstmid i_ack c%0d", c), 32'(iAck[0]), 32'(c == 7));
      checkOutput($sformatf("rstmid m_en c%0d", c),  32'(mEn[0]),  32'(c == 1 || c == 4));
      if (c == 2) checkOutput("rstmid stall forced", 32'(stall[0]), 32'h0);
      if (c == 3) checkOutput("rstmid i_rdata", iRdata[0], 32'h0);
      if (c == 3) checkOutput("rstmid d_rdata", dRdata[0], 32'h0);
      if (c == 3) checkOutput("rstmid stall after", 32'(stall[0]), 32'h1);
      if (c == 7) checkOutput("rstmid reissue i_rdata", iRdata[0], 32'h2002_0005);
      nextCycle();
      if (c == 7) applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    end

    // Both ports requesting continuously: grants go D, I, D, I.
    $display("[TB] continuous contention");
    applyStimulus(0, 1'b1, 32'h300, 1'b1, 1'b0, 32'h44, 32'h0);
    for (int c = 0; c <= 16; c++) begin
      if (c == 16) applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      sample();
      checkOutput($sformatf("rr m_en c%0d", c),  32'(mEn[0]),  32'((c % 4 == 1) && c < 16));
      checkOutput($sformatf("rr d_ack c%0d", c), 32'(dAck[0]), 32'(c == 4 || c == 12));
      checkOutput($sformatf("rr i_ack c%0d", c), 32'(iAck[0]), 32'(c == 8 || c == 16));
      if (c % 4 == 1 && c < 16)
        checkOutput($sformatf("rr m_addr c%0d", c), mAddr[0],
                    ((c / 4) % 2 == 0) ? 32'h44 : 32'h300);
      nextCycle();
    end

    // Latency sweep on the MEM_LAT=1 and MEM_LAT=15 instances.
    $display("[TB] latency sweep");
    applyStimulus(1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(2, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
    lat1  = -1;
    lat15 = -1;
    rd1   = '0;
    rd15  = '0;
    for (int c = 0; c <= 30; c++) begin
      sample();
      if (iAck[1] && lat1 < 0) begin
        lat1 = c;
        rd1  = iRdata[1];
      end
      if (iAck[2] && lat15 < 0) begin
        lat15 = c;
        rd15  = iRdata[2];
      end
      nextCycle();
      if (lat1 >= 0) iReq[1] = 1'b0;
      if (lat15 >= 0) iReq[2] = 1'b0;
    end
    checkOutput("lat1 ack latency",   32'(lat1),  32'd3);
    checkOutput("lat1 i_rdata",       rd1,        32'h2002_0005);
    checkOutput("lat15 ack latency",  32'(lat15), 32'd17);
    checkOutput("lat15 i_rdata",      rd15,       32'hDEAD_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checkCount, errCount);
    $finish;
  end

endmodule
